// File: rtl/brute_force_matcher_match_table_if.sv
// Handshake bundle between the descriptor engine, brute_force_matcher_match_table and the
// host writeback path: the match candidate stream in, and the result FIFO stream out.
interface brute_force_matcher_match_table_if #(
    parameter int C_DIST_WIDTH     = 16,
    parameter int C_KP_INDEX_WIDTH = 12
);
    localparam int MIW = 1 + 2 * C_KP_INDEX_WIDTH + C_DIST_WIDTH;
    localparam int RW  = 2 * C_KP_INDEX_WIDTH + C_DIST_WIDTH;

    logic           match_info_valid;
    logic [MIW-1:0] match_info;
    logic           match_table_ready;
    logic           result_valid;
    logic           result_ready;
    logic [RW-1:0]  result_data;

    modport master (
        output match_info_valid, match_info, result_ready,
        input  match_table_ready, result_valid, result_data
    );

    modport slave (
        input  match_info_valid, match_info, result_ready,
        output match_table_ready, result_valid, result_data
    );
endinterface

// File: rtl/brute_force_matcher_match_table.sv
// Best/second-best match tracker with ratio-test keep/drop and an FWFT result FIFO.
// Define MATCH_TABLE_RATIO_TEST_EN to gate results with the b1*DEN < b2*NUM ratio test.
module brute_force_matcher_match_table #(
    parameter int C_DIST_WIDTH        = 16,
    parameter int C_KP_INDEX_WIDTH    = 12,
    parameter int C_RATIO_NUM         = 4,
    parameter int C_RATIO_DEN         = 5,
    parameter int C_RESULT_FIFO_DEPTH = 16
) (
    input  logic                              compute_clk,
    input  logic                              rst,
    brute_force_matcher_match_table_if.slave  mif,
    output logic [15:0]                       kp_processed,
    output logic                              protocol_error
);
    localparam int DW = C_DIST_WIDTH;
    localparam int KW = C_KP_INDEX_WIDTH;
    localparam int RW = 2 * KW + DW;
    localparam int AW = $clog2(C_RESULT_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(C_RESULT_FIFO_DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW + 1)'(3);

    if (C_RATIO_NUM < 1 || C_RATIO_DEN > 255 || C_RATIO_DEN <= C_RATIO_NUM ||
        C_RESULT_FIFO_DEPTH < 4 || (1 << AW) != C_RESULT_FIFO_DEPTH) begin : g_bad_params
        $error("brute_force_matcher_match_table: illegal parameter combination");
    end

    typedef enum logic [0:0] {ACC_IDLE = 1'b0, ACC_OPEN = 1'b1} acc_state_e;

    acc_state_e    state_q, state_d;
    logic [DW-1:0] b1_q, b1_d, b2_q, b2_d;
    logic [KW-1:0] bidx_q, bidx_d, cur_prim_q, cur_prim_d;
    logic          dec_valid_q, dec_valid_d;
    logic [KW-1:0] dec_prim_q, dec_prim_d, dec_bidx_q, dec_bidx_d;
    logic [DW-1:0] dec_b1_q, dec_b1_d;
    logic [RW-1:0] mem_q [C_RESULT_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d, rvalid_q, rvalid_d;
    logic [15:0]   kp_q, kp_d;
    logic          err_q, err_d;

    logic          accept_s, in_last_s, acc_err_s;
    logic [KW-1:0] in_prim_s, in_sec_s;
    logic [DW-1:0] in_dist_s;
    logic          ratio_pass_s, push_s, push_ok_s, pop_s, overflow_s;

    assign {in_last_s, in_prim_s, in_sec_s, in_dist_s} = mif.match_info;
    assign accept_s = mif.match_info_valid & ready_q;

`ifdef MATCH_TABLE_RATIO_TEST_EN
    localparam int PW = DW + 8;
    logic [DW-1:0] dec_b2_q, dec_b2_d;
    logic [PW-1:0] lhs_s, rhs_s;
    assign lhs_s        = PW'(dec_b1_q) * PW'(C_RATIO_DEN);
    assign rhs_s        = PW'(dec_b2_q) * PW'(C_RATIO_NUM);
    assign ratio_pass_s = (lhs_s < rhs_s);
`else
    assign ratio_pass_s = 1'b1;
`endif

    // Accumulator update and hand-off of a closed keypoint into the decision register.
    always_comb begin
        state_d     = state_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        bidx_d      = bidx_q;
        cur_prim_d  = cur_prim_q;
        dec_valid_d = 1'b0;
        dec_prim_d  = dec_prim_q;
        dec_bidx_d  = dec_bidx_q;
        dec_b1_d    = dec_b1_q;
`ifdef MATCH_TABLE_RATIO_TEST_EN
        dec_b2_d    = dec_b2_q;
`endif
        acc_err_s   = 1'b0;
        if (accept_s) begin
            case (state_q)
                ACC_OPEN: begin
                    // Ties with b1 fall through to b2 so the first index keeps the best slot.
                    if (in_dist_s < b1_q) begin
                        b2_d   = b1_q;
                        b1_d   = in_dist_s;
                        bidx_d = in_sec_s;
                    end else if (in_dist_s < b2_q) begin
                        b2_d = in_dist_s;
                    end else begin
                        b2_d = b2_q;
                    end
                    if (in_prim_s != cur_prim_q) begin
                        acc_err_s = 1'b1;
                    end else begin
                        acc_err_s = 1'b0;
                    end
                end
                default: begin
                    b1_d       = in_dist_s;
                    b2_d       = {DW{1'b1}};
                    bidx_d     = in_sec_s;
                    cur_prim_d = in_prim_s;
                end
            endcase
            if (in_last_s) begin
                dec_valid_d = 1'b1;
                dec_prim_d  = cur_prim_d;
                dec_bidx_d  = bidx_d;
                dec_b1_d    = b1_d;
`ifdef MATCH_TABLE_RATIO_TEST_EN
                dec_b2_d    = b2_d;
`endif
                state_d     = ACC_IDLE;
            end else begin
                state_d = ACC_OPEN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Result FIFO bookkeeping, flow control, keypoint counter and sticky error.
    always_comb begin
        push_s     = dec_valid_q & ratio_pass_s;
        overflow_s = push_s & (count_q == DEPTH_C);
        push_ok_s  = push_s & ~overflow_s;
        pop_s      = rvalid_q & mif.result_ready;
        wr_ptr_d   = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        rvalid_d = (count_d != (AW + 1)'(0));
        ready_d  = ((DEPTH_C - count_q) >= MARGIN_C);
        kp_d     = dec_valid_q ? kp_q + 16'd1 : kp_q;
        err_d    = err_q | acc_err_s | overflow_s;
    end

    // Control, decision and status flops with synchronous reset.
    always_ff @(posedge compute_clk) begin
        if (rst) begin
            state_q     <= ACC_IDLE;
            b1_q        <= {DW{1'b0}};
            b2_q        <= {DW{1'b0}};
            bidx_q      <= {KW{1'b0}};
            cur_prim_q  <= {KW{1'b0}};
            dec_valid_q <= 1'b0;
            dec_prim_q  <= {KW{1'b0}};
            dec_bidx_q  <= {KW{1'b0}};
            dec_b1_q    <= {DW{1'b0}};
`ifdef MATCH_TABLE_RATIO_TEST_EN
            dec_b2_q    <= {DW{1'b0}};
`endif
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW + 1){1'b0}};
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            kp_q        <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            bidx_q      <= bidx_d;
            cur_prim_q  <= cur_prim_d;
            dec_valid_q <= dec_valid_d;
            dec_prim_q  <= dec_prim_d;
            dec_bidx_q  <= dec_bidx_d;
            dec_b1_q    <= dec_b1_d;
`ifdef MATCH_TABLE_RATIO_TEST_EN
            dec_b2_q    <= dec_b2_d;
`endif
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            kp_q        <= kp_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage; only the pointers need reset.
    always_ff @(posedge compute_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= {dec_prim_q, dec_bidx_q, dec_b1_q};
        end
    end

    assign mif.match_table_ready = ready_q;
    assign mif.result_valid      = rvalid_q;
    assign mif.result_data       = rvalid_q ? mem_q[rd_ptr_q] : {RW{1'b0}};
    assign kp_processed          = kp_q;
    assign protocol_error        = err_q;
endmodule

// File: tb/tb_brute_force_matcher_match_table.sv
// Randomized self-checking bench for brute_force_matcher_match_table; the reference model
// keeps each keypoint's candidates in queues and picks best/second-best by plain search.
module tb_brute_force_matcher_match_table;
    localparam int DW = 16, KW = 12, NUM = 4, DEN = 5, DEPTH = 16;
    localparam int RW = 2 * KW + DW;

    logic        compute_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] kp_processed;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [RW-1:0] exp_q[$];
    int  dq[$];
    int  sq[$];
    int  acc_prim;
    bit  acc_open;
    bit  exp_err;
    int  exp_kp;

    brute_force_matcher_match_table_if #(.C_DIST_WIDTH(DW), .C_KP_INDEX_WIDTH(KW)) mif();

    brute_force_matcher_match_table #(
        .C_DIST_WIDTH(DW), .C_KP_INDEX_WIDTH(KW), .C_RATIO_NUM(NUM),
        .C_RATIO_DEN(DEN), .C_RESULT_FIFO_DEPTH(DEPTH)
    ) dut (
        .compute_clk    (compute_clk),
        .rst            (rst),
        .mif            (mif.slave),
        .kp_processed   (kp_processed),
        .protocol_error (protocol_error)
    );

    always #5 compute_clk = ~compute_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Close a keypoint: best = first minimum, second = smallest of the rest (or all-ones).
    task automatic model_decide();
        int i0 = 0;
        int b1, b2;
        bit pass;
        logic [KW-1:0] pv, sv;
        logic [DW-1:0] dv;
        b2 = 65535;
        for (int j = 1; j < dq.size(); j++) if (dq[j] < dq[i0]) i0 = j;
        for (int j = 0; j < dq.size(); j++) if (j != i0 && dq[j] < b2) b2 = dq[j];
        b1 = dq[i0];
        pass = 1'b1;
`ifdef MATCH_TABLE_RATIO_TEST_EN
        pass = (longint'(b1) * DEN < longint'(b2) * NUM);
`endif
        pv = acc_prim[KW-1:0];
        sv = sq[i0][KW-1:0];
        dv = b1[DW-1:0];
        if (pass) exp_q.push_back({pv, sv, dv});
        exp_kp = (exp_kp + 1) % 65536;
    endtask

    task automatic model_beat(input bit l, input int p, input int s, input int d);
        if (!acc_open) begin
            acc_prim = p;
            dq.delete();
            sq.delete();
        end else if (p != acc_prim) begin
            exp_err = 1'b1;
        end
        dq.push_back(d);
        sq.push_back(s);
        if (l) begin
            model_decide();
            acc_open = 1'b0;
        end else begin
            acc_open = 1'b1;
        end
    endtask

    // One cycle: drive at the falling edge, account for the accept/pop the next rising edge makes.
    task automatic drive(input bit v, input bit l, input int p, input int s, input int d,
                         input bit rr, output bit accepted);
        logic [KW-1:0] pv, sv;
        logic [DW-1:0] dv;
        @(negedge compute_clk);
        pv = p[KW-1:0];
        sv = s[KW-1:0];
        dv = d[DW-1:0];
        mif.match_info_valid = v;
        mif.match_info       = {l, pv, sv, dv};
        mif.result_ready     = rr;
        accepted = v && mif.match_table_ready;
        if (accepted) model_beat(l, p, s, d);
        if (mif.result_valid && rr) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_result", mif.result_valid, 1'b0);
            end else begin
                check_eq("result_data", mif.result_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, rr, a);
    endtask

    task automatic send_beat(input bit l, input int p, input int s, input int d, input bit rr);
        bit a;
        int tries = 0;
        do begin
            drive(1'b1, l, p, s, d, rr | (tries > 4), a);
            tries++;
        end while (!a && tries < 200);
        if (!a) check_eq("accept_timeout", mif.match_table_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge compute_clk);
        rst = 1'b1;
        mif.match_info_valid = 1'b0;
        mif.match_info       = '0;
        mif.result_ready     = 1'b0;
        exp_q.delete();
        dq.delete();
        sq.delete();
        acc_open = 1'b0;
        exp_err  = 1'b0;
        exp_kp   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge compute_clk);
            check_eq("rst_ready", mif.match_table_ready, 1'b0);
            check_eq("rst_result_valid", mif.result_valid, 1'b0);
            check_eq("rst_result_data", mif.result_data, 0);
            check_eq("rst_kp_processed", kp_processed, 0);
            check_eq("rst_protocol_error", protocol_error, 1'b0);
        end
        rst = 1'b0;
        @(negedge compute_clk);
        @(negedge compute_clk);
        check_eq("ready_after_rst", mif.match_table_ready, 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_kp"}, kp_processed, exp_kp);
        check_eq({tag, "_err"}, protocol_error, exp_err);
        check_eq({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [RW-1:0] want;
        bit a;
        int k;
        do_reset();

        // Ratio pass: keypoint 7, best 40 at sec 1, second 90.
        send_beat(1'b0, 7, 0, 100, 1'b0);
        send_beat(1'b0, 7, 1, 40, 1'b0);
        send_beat(1'b1, 7, 2, 90, 1'b0);
        idle(3, 1'b0);
        want = {12'd7, 12'd1, 16'd40};
        check_eq("kp7_valid", mif.result_valid, 1'b1);
        check_eq("kp7_data", mif.result_data, want);
        idle(3, 1'b1);
        check_eq("kp7_kp", kp_processed, 1);

        // Ratio fail with the test enabled: 250 >= 220.
        send_beat(1'b0, 3, 0, 50, 1'b0);
        send_beat(1'b1, 3, 1, 55, 1'b0);
        idle(3, 1'b0);
`ifdef MATCH_TABLE_RATIO_TEST_EN
        check_eq("kp3_no_result", mif.result_valid, 1'b0);
`else
        want = {12'd3, 12'd0, 16'd50};
        check_eq("kp3_data", mif.result_data, want);
`endif
        idle(3, 1'b1);
        check_eq("kp3_kp", kp_processed, 2);

        // Single-candidate keypoint: second best stays all-ones.
        send_beat(1'b1, 12'h21, 5, 16'h0FFF, 1'b0);
        idle(3, 1'b0);
        want = {12'h021, 12'd5, 16'h0FFF};
        check_eq("single_data", mif.result_data, want);
        idle(3, 1'b1);

        // Tie: first index keeps best, b2 = 30, ratio fails.
        send_beat(1'b0, 2, 0, 30, 1'b0);
        send_beat(1'b1, 2, 1, 30, 1'b0);
        idle(3, 1'b0);
`ifdef MATCH_TABLE_RATIO_TEST_EN
        check_eq("tie_no_result", mif.result_valid, 1'b0);
`else
        want = {12'd2, 12'd0, 16'd30};
        check_eq("tie_data", mif.result_data, want);
`endif
        idle(3, 1'b1);
        check_quiet("directed");

        // Backpressure: stream one-beat passing keypoints with the consumer stalled.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, 1'b1, 100 + k, k, 10 * k + 1, 1'b0, a);
            if (a) k++;
        end
        check_eq("bp_stored", k, DEPTH);
        check_eq("bp_ready_low", mif.match_table_ready, 1'b0);
        check_eq("bp_result_valid", mif.result_valid, 1'b1);
        check_eq("bp_err", protocol_error, 1'b0);
        idle(25, 1'b1);
        while (k < 20) begin
            send_beat(1'b1, 100 + k, k, 10 * k + 1, 1'b1);
            k++;
        end
        idle(6, 1'b1);
        check_quiet("backpressure");

        // Randomized keypoints, gaps and consumer stalls.
        for (int n = 0; n < 250; n++) begin
            int nb = $urandom_range(1, 4);
            int p  = $urandom_range(0, 4095);
            for (int b = 0; b < nb; b++) begin
                int d;
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 0, 0, 0, $urandom_range(0, 3) != 0, a);
                d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : $urandom_range(0, 65535);
                send_beat(b == nb - 1, p, $urandom_range(0, 4095), d, $urandom_range(0, 3) != 0);
            end
        end
        idle(30, 1'b1);
        check_quiet("random");

        // Primary index change mid-keypoint: sticky error, beat still folded in.
        send_beat(1'b0, 9, 0, 10, 1'b1);
        send_beat(1'b1, 10, 1, 20, 1'b1);
        idle(4, 1'b1);
        check_eq("perr_set", protocol_error, 1'b1);
        send_beat(1'b1, 11, 0, 5, 1'b1);
        idle(4, 1'b1);
        check_quiet("perr_sticky");

        // Reset between beats 1 and 2 discards the keypoint and clears the flag.
        send_beat(1'b0, 4, 0, 10, 1'b1);
        do_reset();
        idle(5, 1'b1);
        check_eq("midrst_no_result", mif.result_valid, 1'b0);
        check_quiet("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
